// File: rtl/shiftreg_debounce_pkg.sv
// Shared constants for the shiftreg_debounce slice: FILTER_LEN legal range
// and the per-bit counter width that covers the whole range.
package shiftreg_debounce_pkg;
  localparam int unsigned FILTER_LEN_MIN = 2;
  localparam int unsigned FILTER_LEN_MAX = 15;
  // Wide enough for FILTER_LEN_MAX-1 so every legal FILTER_LEN shares one width.
  localparam int unsigned CNT_W          = $clog2(FILTER_LEN_MAX);
endpackage

// File: rtl/shiftreg_debounce_bit.sv
// Single-bit run-length debouncer: run counter, stable bit and rise/fall pulses.
// toggle_o is the combinational "stable bit flips on this edge" strobe.
module debounce_bit
  import shiftreg_debounce_pkg::*;
#(
  parameter logic        DEFAULT_STATE = 1'b0,
  parameter int unsigned FILTER_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en_i,
  input  logic sample_i,
  input  logic d_raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic toggle_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, fall_q;
  logic             take, diff;

  assign take     = clk_en_i & sample_i;
  assign diff     = d_raw_i ^ stable_q;
  assign toggle_o = take & diff & (cnt_q == CNT_MAX);

  // Any agreeing sample restarts the run outright.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (take) begin
      if (!diff) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d    = '0;
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Pulses are rewritten every clock so they last exactly one cycle even with clk_en low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= DEFAULT_STATE;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= toggle_o & ~stable_q;
      fall_q   <= toggle_o &  stable_q;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
endmodule

// File: rtl/shiftreg_debounce.sv
// Parallel debouncer for the shiftreg165 word, with optional change-event queue.
// Define SHIFTREG_DEBOUNCE_EVENTS_EN to build the pending mask and priority encoder.
module shiftreg_debounce
  import shiftreg_debounce_pkg::*;
#(
  parameter int unsigned BITS          = 8,
  parameter logic        DEFAULT_STATE = 1'b0,
  parameter int unsigned FILTER_LEN    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic                    sample,
  input  logic [BITS-1:0]         d_raw,
  output logic [BITS-1:0]         d_stable,
  output logic [BITS-1:0]         rise,
  output logic [BITS-1:0]         fall,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [$clog2(BITS)-1:0] ev_bit,
  output logic                    ev_level
);
  localparam int unsigned IDX_W = $clog2(BITS);

  if (FILTER_LEN < FILTER_LEN_MIN || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_len
    $error("shiftreg_debounce: FILTER_LEN out of range");
  end

  logic [BITS-1:0] tog;

  for (genvar i = 0; i < BITS; i++) begin : g_bit
    debounce_bit #(
      .DEFAULT_STATE (DEFAULT_STATE),
      .FILTER_LEN    (FILTER_LEN)
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .clk_en_i (clk_en),
      .sample_i (sample),
      .d_raw_i  (d_raw[i]),
      .stable_o (d_stable[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i]),
      .toggle_o (tog[i])
    );
  end

`ifdef SHIFTREG_DEBOUNCE_EVENTS_EN
  logic [BITS-1:0]  pending_q, pending_d, pop;
  logic [IDX_W-1:0] idx;

  // Lowest pending index wins.
  always_comb begin
    idx = '0;
    for (int i = BITS - 1; i >= 0; i--) begin
      if (pending_q[i]) idx = IDX_W'(i);
    end
  end

  assign ev_valid = |pending_q;
  assign ev_bit   = idx;
  assign ev_level = d_stable[idx];

  // Set after clear: a toggle on the pop edge keeps the event alive.
  assign pop       = (ev_valid && ev_ready) ? ({{(BITS-1){1'b0}}, 1'b1} << idx) : '0;
  assign pending_d = (pending_q & ~pop) | tog;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end
`else
  logic unused_ev;
  assign unused_ev = ev_ready ^ (^tog);
  assign ev_valid  = 1'b0;
  assign ev_bit    = '0;
  assign ev_level  = 1'b0;
`endif
endmodule

// File: tb/tb_shiftreg_debounce.sv
// Directed bench for shiftreg_debounce (BITS=8, FILTER_LEN=4, DEFAULT_STATE=0).
// Event checks follow SHIFTREG_DEBOUNCE_EVENTS_EN; without it ev_* must stay 0.
module tb_shiftreg_debounce;
  logic       clk = 1'b0;
  logic       rst_n, clk_en, sample, ev_ready;
  logic [7:0] d_raw, d_stable, rise, fall;
  logic       ev_valid, ev_level;
  logic [2:0] ev_bit;
  int         n_cmp = 0;
  int         n_err = 0;

  shiftreg_debounce #(.BITS(8), .DEFAULT_STATE(1'b0), .FILTER_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .sample(sample), .d_raw(d_raw),
    .d_stable(d_stable), .rise(rise), .fall(fall), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_bit(ev_bit), .ev_level(ev_level)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clk_en = 1'b1; sample = 1'b1; ev_ready = 1'b0; d_raw = 8'h00;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1; sample = 1'b1; ev_ready = 1'b1; d_raw = 8'hff;
    tick(6);
    n_cmp++; if (d_stable !== 8'h00) begin n_err++; $display("FAIL reset_stable: got %h want 00", d_stable); end
    n_cmp++; if ((rise | fall) !== 8'h00) begin n_err++; $display("FAIL reset_pulses: got %h/%h want 00/00", rise, fall); end
    n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_ev_valid: got %b want 0", ev_valid); end
    d_raw = 8'h00; ev_ready = 1'b0; rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_accept();
    do_reset();
    d_raw = 8'h01;
    tick(3);
    n_cmp++; if (d_stable !== 8'h00) begin n_err++; $display("FAIL acc_early: got %h want 00", d_stable); end
    tick(1);
    n_cmp++; if (d_stable !== 8'h01) begin n_err++; $display("FAIL acc_stable: got %h want 01", d_stable); end
    n_cmp++; if (rise !== 8'h01) begin n_err++; $display("FAIL acc_rise: got %h want 01", rise); end
`ifdef SHIFTREG_DEBOUNCE_EVENTS_EN
    n_cmp++; if ({ev_valid, ev_bit, ev_level} !== {1'b1, 3'd0, 1'b1}) begin n_err++;
      $display("FAIL acc_event: got v%b b%0d l%b want v1 b0 l1", ev_valid, ev_bit, ev_level); end
`else
    n_cmp++; if ({ev_valid, ev_bit, ev_level} !== 5'b0) begin n_err++;
      $display("FAIL acc_ev_tied: got v%b b%0d l%b want all 0", ev_valid, ev_bit, ev_level); end
`endif
    tick(1);
    n_cmp++; if (rise !== 8'h00) begin n_err++; $display("FAIL acc_rise_end: got %h want 00", rise); end
    n_cmp++; if (d_stable !== 8'h01) begin n_err++; $display("FAIL acc_hold: got %h want 01", d_stable); end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      d_raw = (k == 3) ? 8'h00 : 8'h01;
      tick(1);
      n_cmp++; if ({d_stable, rise, fall} !== 24'h0) begin n_err++;
        $display("FAIL glitch_s%0d: got %h/%h/%h want 00/00/00", k, d_stable, rise, fall); end
    end
  endtask

  task automatic test_enable();
    do_reset();
    d_raw = 8'h10;
    tick(3);
    clk_en = 1'b0;
    tick(3);
    n_cmp++; if (d_stable !== 8'h00) begin n_err++; $display("FAIL en_hold: got %h want 00", d_stable); end
    clk_en = 1'b1; sample = 1'b0;
    tick(2);
    n_cmp++; if (d_stable !== 8'h00) begin n_err++; $display("FAIL smp_hold: got %h want 00", d_stable); end
    sample = 1'b1;
    tick(1);
    n_cmp++; if ((d_stable !== 8'h10) || (rise !== 8'h10)) begin n_err++;
      $display("FAIL en_accept: got %h/%h want 10/10", d_stable, rise); end
    clk_en = 1'b0;
    tick(1);
    n_cmp++; if (rise !== 8'h00) begin n_err++; $display("FAIL en_pulse_end: got %h want 00", rise); end
    clk_en = 1'b1;
  endtask

  task automatic test_two_bits();
    do_reset();
    ev_ready = 1'b1; d_raw = 8'h24;
    tick(4);
    n_cmp++; if ((d_stable !== 8'h24) || (rise !== 8'h24)) begin n_err++;
      $display("FAIL two_accept: got %h/%h want 24/24", d_stable, rise); end
`ifdef SHIFTREG_DEBOUNCE_EVENTS_EN
    n_cmp++; if ({ev_valid, ev_bit, ev_level} !== {1'b1, 3'd2, 1'b1}) begin n_err++;
      $display("FAIL two_first: got v%b b%0d l%b want v1 b2 l1", ev_valid, ev_bit, ev_level); end
    tick(1);
    n_cmp++; if ({ev_valid, ev_bit, ev_level} !== {1'b1, 3'd5, 1'b1}) begin n_err++;
      $display("FAIL two_second: got v%b b%0d l%b want v1 b5 l1", ev_valid, ev_bit, ev_level); end
    tick(1);
    n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL two_drain: got %b want 0", ev_valid); end
`else
    tick(2);
    n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL two_ev_tied: got %b want 0", ev_valid); end
`endif
    ev_ready = 1'b0;
  endtask

  task automatic test_coalesce();
    do_reset();
    d_raw = 8'h08;
    tick(4);
    n_cmp++; if (d_stable !== 8'h08) begin n_err++; $display("FAIL co_rise: got %h want 08", d_stable); end
    d_raw = 8'h00;
    tick(4);
    n_cmp++; if ((d_stable !== 8'h00) || (fall !== 8'h08)) begin n_err++;
      $display("FAIL co_fall: got %h/%h want 00/08", d_stable, fall); end
`ifdef SHIFTREG_DEBOUNCE_EVENTS_EN
    n_cmp++; if ({ev_valid, ev_bit, ev_level} !== {1'b1, 3'd3, 1'b0}) begin n_err++;
      $display("FAIL co_event: got v%b b%0d l%b want v1 b3 l0", ev_valid, ev_bit, ev_level); end
    tick(2);
    n_cmp++; if ({ev_valid, ev_bit, ev_level} !== {1'b1, 3'd3, 1'b0}) begin n_err++;
      $display("FAIL co_stall: got v%b b%0d l%b want v1 b3 l0", ev_valid, ev_bit, ev_level); end
    ev_ready = 1'b1;
    tick(1);
    n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL co_pop: got %b want 0", ev_valid); end
`endif
    ev_ready = 1'b0;
  endtask

  task automatic test_pop_collide();
    do_reset();
    d_raw = 8'h02;
    tick(4);
    d_raw = 8'h00;
    tick(3);
    n_cmp++; if (d_stable !== 8'h02) begin n_err++; $display("FAIL pc_pre: got %h want 02", d_stable); end
    ev_ready = 1'b1;
    tick(1);
    n_cmp++; if ((d_stable !== 8'h00) || (fall !== 8'h02)) begin n_err++;
      $display("FAIL pc_toggle: got %h/%h want 00/02", d_stable, fall); end
`ifdef SHIFTREG_DEBOUNCE_EVENTS_EN
    n_cmp++; if ({ev_valid, ev_bit, ev_level} !== {1'b1, 3'd1, 1'b0}) begin n_err++;
      $display("FAIL pc_keep: got v%b b%0d l%b want v1 b1 l0", ev_valid, ev_bit, ev_level); end
    tick(1);
    n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL pc_clear: got %b want 0", ev_valid); end
`endif
    ev_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    d_raw = 8'h01;
    tick(2);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({d_stable, rise, fall, ev_valid} !== 25'h0) begin n_err++;
      $display("FAIL mr_async: got %h/%h/%h/%b want all 0", d_stable, rise, fall, ev_valid); end
    tick(1);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      n_cmp++; if ({d_stable, rise} !== 16'h0) begin n_err++;
        $display("FAIL mr_s%0d: got %h/%h want 00/00", k, d_stable, rise); end
    end
    tick(1);
    n_cmp++; if ((d_stable !== 8'h01) || (rise !== 8'h01)) begin n_err++;
      $display("FAIL mr_accept: got %h/%h want 01/01", d_stable, rise); end
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b0; sample = 1'b0; ev_ready = 1'b0; d_raw = 8'h00;
    test_reset();
    test_accept();
    test_glitch();
    test_enable();
    test_two_bits();
    test_coalesce();
    test_pop_collide();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/shiftreg_debounce.md
SHIFTREG_DEBOUNCE -- requirements
Module: shiftreg_debounce

Interface
REQ-001 Parameter BITS, default 8: width of the raw input word and the debounced output word.
REQ-002 Parameter DEFAULT_STATE, default 1'b0: reset level of every stable bit.
REQ-003 Parameter FILTER_LEN, default 4, legal range 2..15: number of consecutive differing samples needed to accept a change.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clk_en  input  1  clock enable; the filter advances only when it is 1.
REQ-007 sample  input  1  sample strobe; a sample is taken when clk_en && sample.
REQ-008 d_raw  input  BITS  parallel word from the upstream shiftreg165 d output.
REQ-009 d_stable  output  BITS  debounced word, registered.
REQ-010 rise  output  BITS  one-clk pulse per bit on each accepted 0->1 change.
REQ-011 fall  output  BITS  one-clk pulse per bit on each accepted 1->0 change.
REQ-012 ev_valid  output  1  a change event is pending.
REQ-013 ev_ready  input  1  the consumer accepts the presented event.
REQ-014 ev_bit  output  $clog2(BITS)  index of the presented event.
REQ-015 ev_level  output  1  current d_stable level of bit ev_bit.

Function
REQ-016 The block SHALL keep one counter per bit, cnt[i], wide enough to hold FILTER_LEN-1.
REQ-017 On a sample where d_raw[i]==d_stable[i], cnt[i] SHALL clear to 0.
REQ-018 On a sample where d_raw[i]!=d_stable[i] and cnt[i]<FILTER_LEN-1, cnt[i] SHALL increment.
REQ-019 On a sample where d_raw[i]!=d_stable[i] and cnt[i]==FILTER_LEN-1, the block SHALL toggle d_stable[i] and clear cnt[i] on that edge.
REQ-020 An input held steadily at the new level SHALL therefore be accepted on the FILTER_LEN-th consecutive sample, with zero extra clock latency after that sample edge.
REQ-021 A single agreeing sample within a run SHALL restart the run; the count does not decay gradually.
REQ-022 rise[i] and fall[i] SHALL be high for exactly the one clk cycle after the edge on which d_stable[i] toggles, regardless of clk_en.
REQ-023 Bits SHALL be filtered independently; several bits may toggle on the same sample.
REQ-024 With clk_en=0 or sample=0, counters and d_stable SHALL hold.

Event queue (only when SHIFTREG_DEBOUNCE_EVENTS_EN is defined)
REQ-025 A BITS-wide pending mask SHALL set bit i whenever d_stable[i] toggles.
REQ-026 ev_valid SHALL equal OR(pending); ev_bit SHALL be the lowest set index; ev_level SHALL be d_stable[ev_bit].
REQ-027 When ev_valid && ev_ready on an edge, pending[ev_bit] SHALL clear; this handshake ignores clk_en.
REQ-028 If the same edge both pops bit i and toggles bit i, set SHALL win and pending[i] SHALL stay 1.
REQ-029 Repeated toggles of a pending bit SHALL coalesce into one event, and ev_level SHALL always show the current level.
REQ-030 ev_bit, ev_level and ev_valid SHALL be stable while ev_valid=1 && ev_ready=0, unless a lower-index bit becomes pending.

Reset
REQ-031 While rst_n=0: d_stable={BITS{DEFAULT_STATE}}, all cnt=0, rise=fall=0, pending=0, ev_valid=0.
REQ-032 Reset asserted mid-run SHALL discard partial counts and pending events, with no pulse on release.

Configuration
REQ-033 Macro SHIFTREG_DEBOUNCE_EVENTS_EN defined: the event queue of REQ-025..030 SHALL be built.
REQ-034 Macro undefined: no pending registers SHALL be built; ev_valid, ev_bit and ev_level SHALL be tied to 0 and ev_ready ignored; all ports SHALL remain present.

Structure
REQ-035 The shared package SHALL hold the counter-width helper constant and the FILTER_LEN legal-range limits; no typedefs are required.
REQ-036 Per-bit filtering SHALL be one sub-module, debounce_bit (counter, stable bit, rise/fall), instantiated BITS times by generate.
REQ-037 The priority encoder and pending mask SHALL live in the top module.

Verification (BITS=8, FILTER_LEN=4, DEFAULT_STATE=0, clk_en=1)
REQ-038 Test: d_raw=8'h01 for 4 samples -> d_stable[0]=1 after 4th sample edge; rise=8'h01 for one cycle; ev_valid=1, ev_bit=0, ev_level=1.
REQ-039 Test: d_raw 8'h01 for 3 samples, 8'h00 for 1, 8'h01 for 3 -> d_stable stays 8'h00; no pulses.
REQ-040 Test: bits 5 and 2 accepted on the same sample, ev_ready=1 -> ev_bit 2 is presented, then 5; ev_valid drops after 2 handshakes.
REQ-041 Test: bit 3 rises then falls, ev_ready=0 throughout -> one pending event with ev_level=0; one handshake clears it.
REQ-042 Test: pop bit 1 on the same edge bit 1 toggles -> ev_valid stays 1, ev_bit=1, ev_level=new level.
REQ-043 Test: rst_n pulsed low after 2 mismatching samples -> all outputs at reset values; 4 fresh samples are needed to accept the change.
